mem_load_queue: RTL and testbench

Parametrised in-order load-result queue for the MEM stage of the dual-issue MIPS core. It replaces the single stall-hold read-data register, so the pipeline tolerates up to DEPTH outstanding AXI data reads. It tracks issued loads, accepts in-order read responses and performs byte/half/word/LWL/LWR alignment. Aligned results go to WB under a valid/ready handshake. On flush it discards in-flight loads and silently drops their late responses.

---
 rtl/mem_load_queue_pkg.sv | 17 +
 rtl/mem_load_align.sv | 56 +++++
 rtl/mem_load_queue.sv | 148 ++++++++++++++
 tb/tb_mem_load_queue.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_load_queue_pkg.sv
// Shared load-queue definitions: load opcode encodings and field widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_load_queue_pkg;

  localparam int unsigned LD_OP_WD   = 3;
  localparam int unsigned RF_ADDR_WD = 5;

  localparam logic [LD_OP_WD-1:0] LD_LB  = 3'd0;
  localparam logic [LD_OP_WD-1:0] LD_LBU = 3'd1;
  localparam logic [LD_OP_WD-1:0] LD_LH  = 3'd2;
  localparam logic [LD_OP_WD-1:0] LD_LHU = 3'd3;
  localparam logic [LD_OP_WD-1:0] LD_LW  = 3'd4;
  localparam logic [LD_OP_WD-1:0] LD_LWL = 3'd5;
  localparam logic [LD_OP_WD-1:0] LD_LWR = 3'd6;

endpackage

// File: rtl/mem_load_align.sv
// Load data aligner: byte/half/word extraction and LWL/LWR merge with old rt.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module mem_load_align
  import mem_load_queue_pkg::*;
(
  input  logic [LD_OP_WD-1:0] op,
  input  logic [1:0]          addr_lo,
  input  logic [31:0]         rt,
  input  logic [31:0]         rd,
  output logic [31:0]         result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half, then extend or merge according to the opcode.
  always_comb begin
    byte_sel = rd[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rd[7:0];
      2'd1:    byte_sel = rd[15:8];
      2'd2:    byte_sel = rd[23:16];
      default: byte_sel = rd[31:24];
    endcase
    half_sel = addr_lo[1] ? rd[31:16] : rd[15:0];

    result = '0;
    case (op)
      LD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: result = {24'h0, byte_sel};
      // Odd halfword addresses trap upstream; the value here is don't-care, forced to 0.
      LD_LH:  result = addr_lo[0] ? 32'h0 : {{16{half_sel[15]}}, half_sel};
      LD_LHU: result = addr_lo[0] ? 32'h0 : {16'h0, half_sel};
      LD_LW:  result = rd;
      LD_LWL: begin
        case (addr_lo)
          2'd0:    result = {rd[7:0],  rt[23:0]};
          2'd1:    result = {rd[15:0], rt[15:0]};
          2'd2:    result = {rd[23:0], rt[7:0]};
          default: result = rd;
        endcase
      end
      LD_LWR: begin
        case (addr_lo)
          2'd0:    result = rd;
          2'd1:    result = {rt[31:24], rd[31:8]};
          2'd2:    result = {rt[31:16], rd[31:16]};
          default: result = {rt[31:8],  rd[31:24]};
        endcase
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_load_queue.sv
// In-order load-result queue: tracks issued loads, aligns in-order read beats, hands results to WB.
// Latency: a response to the head entry shows as wb_valid one cycle later.
// Backpressure: req_ready drops when live plus to-be-dropped reads reach DEPTH; wb_ready low holds the head.
module mem_load_queue
  import mem_load_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LD_OP_WD-1:0]   req_op,
  input  logic [1:0]            req_addr_lo,
  input  logic [31:0]           req_rt_data,
  input  logic [RF_ADDR_WD-1:0] req_waddr,
  input  logic [PC_W-1:0]       req_pc,
  input  logic                  rsp_valid,
  input  logic [31:0]           rsp_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [RF_ADDR_WD-1:0] wb_waddr,
  output logic [31:0]           wb_wdata,
  output logic [PC_W-1:0]       wb_pc,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  rsp_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Per-entry control state (reset) and payload (no reset needed, guarded by valid).
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      data_ok_q;
  logic [LD_OP_WD-1:0]   op_q      [DEPTH];
  logic [1:0]            addr_lo_q [DEPTH];
  logic [31:0]           rt_data_q [DEPTH];
  logic [RF_ADDR_WD-1:0] waddr_q   [DEPTH];
  logic [PC_W-1:0]       pc_q      [DEPTH];
  logic [31:0]           result_q  [DEPTH];

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] fill_ptr;

  logic [CNT_W:0]   occ_sum;
  logic [CNT_W-1:0] unfilled;
  logic [CNT_W-1:0] flush_drop;
  logic             fill_hit;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             rsp_bad;
  logic             push;
  logic             pop;
  logic [31:0]      align_result;

  // Discarded reads still occupy memory-side slots, so they count against admission.
  assign occ_sum   = {1'b0, count} + {1'b0, drop_cnt};
  assign req_ready = (occ_sum < (CNT_W + 1)'(DEPTH));
  assign push      = req_valid & req_ready & ~flush;

  // Responses arrive in order: owed drops first, then the oldest unfilled entry.
  assign fill_hit  = valid_q[fill_ptr] & ~data_ok_q[fill_ptr];
  assign rsp_drop  = rsp_valid & (drop_cnt != '0);
  assign rsp_fill  = rsp_valid & ~rsp_drop & fill_hit;
  assign rsp_bad   = rsp_valid & ~rsp_drop & ~fill_hit;

  assign wb_valid  = valid_q[head_ptr] & data_ok_q[head_ptr] & ~flush;
  assign pop       = wb_valid & wb_ready;
  assign wb_waddr  = wb_valid ? waddr_q[head_ptr]  : '0;
  assign wb_wdata  = wb_valid ? result_q[head_ptr] : '0;
  assign wb_pc     = wb_valid ? pc_q[head_ptr]     : '0;

  // Count loads still waiting on memory; on flush their beats become owed drops.
  always_comb begin
    unfilled = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !data_ok_q[i]) unfilled = unfilled + CNT_W'(1);
    end
  end

  assign flush_drop = drop_cnt + unfilled - CNT_W'(rsp_fill) - CNT_W'(rsp_drop);

  mem_load_align u_align (
    .op      (op_q[fill_ptr]),
    .addr_lo (addr_lo_q[fill_ptr]),
    .rt      (rt_data_q[fill_ptr]),
    .rd      (rsp_rdata),
    .result  (align_result)
  );

  // Control state: pointers, occupancy, valid/data_ok flags, drop counter, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      data_ok_q <= '0;
      head_ptr  <= '0;
      tail_ptr  <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (rsp_bad) rsp_err <= 1'b1;
      if (flush) begin
        valid_q   <= '0;
        data_ok_q <= '0;
        head_ptr  <= '0;
        tail_ptr  <= '0;
        fill_ptr  <= '0;
        count     <= '0;
        drop_cnt  <= flush_drop;
      end else begin
        if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
        if (rsp_fill) begin
          data_ok_q[fill_ptr] <= 1'b1;
          fill_ptr            <= fill_ptr + PTR_W'(1);
        end
        if (push) begin
          valid_q[tail_ptr]   <= 1'b1;
          data_ok_q[tail_ptr] <= 1'b0;
          tail_ptr            <= tail_ptr + PTR_W'(1);
        end
        if (pop) begin
          valid_q[head_ptr] <= 1'b0;
          head_ptr          <= head_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Payload capture: request fields on push, aligned data on fill.
  always_ff @(posedge clk) begin
    if (push) begin
      op_q[tail_ptr]      <= req_op;
      addr_lo_q[tail_ptr] <= req_addr_lo;
      rt_data_q[tail_ptr] <= req_rt_data;
      waddr_q[tail_ptr]   <= req_waddr;
      pc_q[tail_ptr]      <= req_pc;
    end
    if (rsp_fill) result_q[fill_ptr] <= align_result;
  end

endmodule

// File: tb/tb_mem_load_queue.sv
// Directed self-checking bench for mem_load_queue (DEPTH=4).
// Latency: inputs driven 1ns after posedge, outputs sampled after settling.
// Backpressure: wb_ready driven explicitly per scenario.
module tb_mem_load_queue;
  import mem_load_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = 3;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [1:0]        req_addr_lo;
  logic [31:0]       req_rt_data;
  logic [4:0]        req_waddr;
  logic [PC_W-1:0]   req_pc;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_waddr;
  logic [31:0]       wb_wdata;
  logic [PC_W-1:0]   wb_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  drop_cnt;
  logic              rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_load_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr_lo (req_addr_lo),
    .req_rt_data (req_rt_data),
    .req_waddr   (req_waddr),
    .req_pc      (req_pc),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .wb_pc       (wb_pc),
    .count       (count),
    .drop_cnt    (drop_cnt),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    req_valid   = 1'b0;
    req_op      = '0;
    req_addr_lo = '0;
    req_rt_data = '0;
    req_waddr   = '0;
    req_pc      = '0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    wb_ready    = 1'b0;
  endtask

  task automatic push_set(input logic [2:0] op, input logic [1:0] a, input logic [31:0] rt,
                          input logic [4:0] wa, input logic [31:0] pc);
    req_valid   = 1'b1;
    req_op      = op;
    req_addr_lo = a;
    req_rt_data = rt;
    req_waddr   = wa;
    req_pc      = pc;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (drop_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", rsp_err); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wbv: got %b want 0", wb_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_cmp++; if (wb_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", wb_wdata); end
    n_cmp++; if (wb_waddr !== 5'd0) begin n_bad++; $display("FAIL rst_waddr: got %h want 0", wb_waddr); end
    n_cmp++; if (wb_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", wb_pc); end
  endtask

  task automatic test_single_load();
    push_set(LD_LB, 2'd3, 32'h0, 5'd5, 32'h100);
    cyc();
    idle();
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", count); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL single_wbv_pre: got %b want 0", wb_valid); end
    rsp_valid = 1'b1;
    rsp_rdata = 32'h80FF_1234;
    cyc();
    idle();
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL single_wbv: got %b want 1", wb_valid); end
    n_cmp++; if (wb_wdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL single_wdata: got %h want ffffff80", wb_wdata); end
    n_cmp++; if (wb_waddr !== 5'd5) begin n_bad++; $display("FAIL single_waddr: got %0d want 5", wb_waddr); end
    n_cmp++; if (wb_pc !== 32'h100) begin n_bad++; $display("FAIL single_pc: got %h want 100", wb_pc); end
    wb_ready = 1'b1;
    cyc();
    idle();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL single_count_post: got %0d want 0", count); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL single_wbv_post: got %b want 0", wb_valid); end
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_pre%0d: got %b want 1", i, req_ready); end
      push_set(LD_LW, 2'd0, 32'h0, 5'(i + 1), 32'h200 + 32'(4 * i));
      cyc();
    end
    idle();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL bp_count_full: got %0d want 4", count); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", req_ready); end
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1'b1;
      rsp_rdata = 32'h1000_0001 + 32'(i);
      cyc();
      idle();
    end
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL bp_wbv_held: got %b want 1", wb_valid); end
    n_cmp++; if (wb_wdata !== 32'h1000_0001) begin n_bad++; $display("FAIL bp_head_held: got %h want 10000001", wb_wdata); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL bp_count_held: got %0d want 4", count); end
    // Full queue: a push in the same cycle as a pop must still be refused.
    push_set(LD_LW, 2'd0, 32'h0, 5'd9, 32'h999);
    wb_ready = 1'b1;
    cyc();
    idle();
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL bp_full_pop_push: got %0d want 3", count); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (wb_wdata !== 32'h1000_0001 + 32'(i)) begin n_bad++; $display("FAIL bp_drain_data%0d: got %h want %h", i, wb_wdata, 32'h1000_0001 + 32'(i)); end
      n_cmp++; if (wb_waddr !== 5'(i + 1)) begin n_bad++; $display("FAIL bp_drain_waddr%0d: got %0d want %0d", i, wb_waddr, i + 1); end
      n_cmp++; if (wb_pc !== 32'h200 + 32'(4 * i)) begin n_bad++; $display("FAIL bp_drain_pc%0d: got %h want %h", i, wb_pc, 32'h200 + 32'(4 * i)); end
      wb_ready = 1'b1;
      cyc();
      idle();
    end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL bp_count_empty: got %0d want 0", count); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL bp_wbv_empty: got %b want 0", wb_valid); end
  endtask

  task automatic test_lwl_lwr();
    logic [2:0]  ops  [4] = '{LD_LWL, LD_LWR, LD_LH, LD_LHU};
    logic [1:0]  adrs [4] = '{2'd1, 2'd2, 2'd2, 2'd1};
    logic [31:0] rds  [4] = '{32'h1122_3344, 32'h1122_3344, 32'h8001_0000, 32'h1234_5678};
    logic [31:0] exps [4] = '{32'h3344_CCDD, 32'hAABB_1122, 32'hFFFF_8001, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      push_set(ops[i], adrs[i], 32'hAABB_CCDD, 5'(7 + i), 32'h300 + 32'(4 * i));
      cyc();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1'b1;
      rsp_rdata = rds[i];
      cyc();
      idle();
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL align_wbv%0d: got %b want 1", i, wb_valid); end
      n_cmp++; if (wb_wdata !== exps[i]) begin n_bad++; $display("FAIL align_data%0d: got %h want %h", i, wb_wdata, exps[i]); end
      wb_ready = 1'b1;
      cyc();
      idle();
    end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL align_count: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      push_set(LD_LW, 2'd0, 32'h0, 5'(20 + i), 32'h400 + 32'(4 * i));
      cyc();
    end
    idle();
    rsp_valid = 1'b1;
    rsp_rdata = 32'h5555_0000;
    cyc();
    idle();
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL flush_head_ready: got %b want 1", wb_valid); end
    // Three unfilled entries, and this beat lands on one of them: two beats remain owed.
    flush     = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h6666_0000;
    wb_ready  = 1'b1;
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_wbv_gate: got %b want 0", wb_valid); end
    cyc();
    idle();
    n_cmp++; if (drop_cnt !== 3'd2) begin n_bad++; $display("FAIL flush_drop: got %0d want 2", drop_cnt); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 2; i++) begin
      rsp_valid = 1'b1;
      rsp_rdata = 32'h7777_0000 + 32'(i);
      cyc();
      idle();
      n_cmp++; if (drop_cnt !== 3'(1 - i)) begin n_bad++; $display("FAIL flush_dropping%0d: got %0d want %0d", i, drop_cnt, 1 - i); end
      n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_dropped_wbv%0d: got %b want 0", i, wb_valid); end
    end
    push_set(LD_LW, 2'd0, 32'h0, 5'd13, 32'h480);
    cyc();
    idle();
    rsp_valid = 1'b1;
    rsp_rdata = 32'hDEAD_BEEF;
    cyc();
    idle();
    n_cmp++; if (wb_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL flush_new_data: got %h want deadbeef", wb_wdata); end
    n_cmp++; if (wb_waddr !== 5'd13) begin n_bad++; $display("FAIL flush_new_waddr: got %0d want 13", wb_waddr); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL flush_err: got %b want 0", rsp_err); end
    wb_ready = 1'b1;
    cyc();
    idle();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL flush_count_post: got %0d want 0", count); end
  endtask

  task automatic test_simultaneous();
    push_set(LD_LW, 2'd0, 32'h0, 5'd1, 32'h500);
    cyc();
    push_set(LD_LW, 2'd0, 32'h0, 5'd2, 32'h504);
    cyc();
    idle();
    rsp_valid = 1'b1;
    rsp_rdata = 32'hAAAA_0001;
    cyc();
    idle();
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL sim_count_pre: got %0d want 2", count); end
    n_cmp++; if (wb_wdata !== 32'hAAAA_0001) begin n_bad++; $display("FAIL sim_head_a: got %h want aaaa0001", wb_wdata); end
    // Push C, fill B and pop A in the same cycle.
    push_set(LD_LW, 2'd0, 32'h0, 5'd3, 32'h508);
    rsp_valid = 1'b1;
    rsp_rdata = 32'hBBBB_0002;
    wb_ready  = 1'b1;
    cyc();
    idle();
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL sim_count_same: got %0d want 2", count); end
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL sim_wbv_b: got %b want 1", wb_valid); end
    n_cmp++; if (wb_wdata !== 32'hBBBB_0002) begin n_bad++; $display("FAIL sim_head_b: got %h want bbbb0002", wb_wdata); end
    n_cmp++; if (wb_waddr !== 5'd2) begin n_bad++; $display("FAIL sim_waddr_b: got %0d want 2", wb_waddr); end
    rsp_valid = 1'b1;
    rsp_rdata = 32'hCCCC_0003;
    wb_ready  = 1'b1;
    cyc();
    idle();
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL sim_count_c: got %0d want 1", count); end
    n_cmp++; if (wb_wdata !== 32'hCCCC_0003) begin n_bad++; $display("FAIL sim_head_c: got %h want cccc0003", wb_wdata); end
    n_cmp++; if (wb_pc !== 32'h508) begin n_bad++; $display("FAIL sim_pc_c: got %h want 508", wb_pc); end
    wb_ready = 1'b1;
    cyc();
    idle();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL sim_count_empty: got %0d want 0", count); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL sim_err_pre: got %b want 0", rsp_err); end
    rsp_valid = 1'b1;
    rsp_rdata = 32'h0000_1234;
    cyc();
    idle();
    n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL sim_err_unsolicited: got %b want 1", rsp_err); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL sim_count_unsol: got %0d want 0", count); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL sim_wbv_unsol: got %b want 0", wb_valid); end
    cyc();
    n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL sim_err_sticky: got %b want 1", rsp_err); end
  endtask

  task automatic test_reset_mid();
    push_set(LD_LW, 2'd0, 32'h0, 5'd30, 32'h600);
    cyc();
    push_set(LD_LH, 2'd0, 32'h0, 5'd31, 32'h604);
    cyc();
    idle();
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL rmid_count_pre: got %0d want 2", count); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rmid_count: got %0d want 0", count); end
    n_cmp++; if (drop_cnt !== 3'd0) begin n_bad++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_wbv: got %b want 0", wb_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rmid_err: got %b want 0", rsp_err); end
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_load();
    test_back_pressure();
    test_lwl_lwr();
    test_flush();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
